puf_crp_controller: RTL and testbench

Sequencing controller for the arbiter-PUF challenge path. It steps the external challenge LFSR one state per challenge, fires the PUF race, and waits a programmable settle time. It then samples the 1-bit arbiter response and packs responses into RESP_W-bit words, delivered over a valid/ready port. It sits between the host/test logic (start, count, output sink) and the LFSR + arbiter-PUF datapath.

---
 rtl/puf_ctrl_pkg.sv | 32 +++
 rtl/puf_resp_packer.sv | 52 +++++
 rtl/puf_crp_controller.sv | 195 +++++++++++++++++++
 tb/tb_puf_crp_controller.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/puf_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// puf_ctrl_pkg
// Shared definitions for the arbiter-PUF challenge/response controller:
//   - state_t       : controller state enum with fixed encodings
//   - RESP_W_DEF    : default number of responses packed per output word
//   - CNT_W_DEF     : default width of the CRP count
//   - nbits_w()     : width of a "valid bits in word" field for a given word
//                     size (must hold the value RESP_W itself)
// -----------------------------------------------------------------------------
package puf_ctrl_pkg;

    localparam int STATE_W    = 3;
    localparam int RESP_W_DEF = 32;
    localparam int CNT_W_DEF  = 16;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE    = 3'd0,
        S_STEP    = 3'd1,
        S_LAUNCH  = 3'd2,
        S_SETTLE  = 3'd3,
        S_CAPTURE = 3'd4,
        S_EMIT    = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    // A word holding RESP_W responses needs a count field that can say RESP_W,
    // hence one bit more than the bit index.
    function automatic int nbits_w(input int resp_w);
        return $clog2(resp_w) + 1;
    endfunction

endpackage

// File: rtl/puf_resp_packer.sv
// -----------------------------------------------------------------------------
// puf_resp_packer
// Collects 1-bit arbiter responses into a RESP_W-bit word, first response in
// bit 0. Unwritten high bits stay 0, so a partial word is zero-padded.
// Ports:
//   clk, rst     : clock, asynchronous active-low reset
//   clr          : empty the word and zero the bit count (has priority)
//   wr_en        : store bit_in at position bit_cnt and advance bit_cnt
//   bit_in       : response bit to store
//   data         : packed word
//   bit_cnt      : number of responses currently held
//   full         : only the top slot is left, so the next write fills the word
// -----------------------------------------------------------------------------
module puf_resp_packer
    import puf_ctrl_pkg::*;
#(
    parameter int RESP_W = RESP_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       wr_en,
    input  logic                       bit_in,
    output logic [RESP_W-1:0]          data,
    output logic [nbits_w(RESP_W)-1:0] bit_cnt,
    output logic                       full
);

    localparam int NB_W = nbits_w(RESP_W);

    // NOTE: the packed word is an ordinary register, not a RAM, so it is
    // reset together with the count; that keeps out_data at 0 out of reset.
    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data    <= '0;
            bit_cnt <= '0;
        end else if (clr) begin
            data    <= '0;
            bit_cnt <= '0;
        end else if (wr_en) begin
            // OR-in a one-hot shifted response; slots are only ever written once
            // between clears, so OR is equivalent to a bit assignment.
            data    <= data | (RESP_W'(bit_in) << bit_cnt);
            bit_cnt <= bit_cnt + NB_W'(1);
        end
    end

    assign full = (bit_cnt == NB_W'(RESP_W - 1));

endmodule

// File: rtl/puf_crp_controller.sv
// -----------------------------------------------------------------------------
// puf_crp_controller
// Sequences the arbiter-PUF challenge path: steps the external challenge LFSR
// once per CRP, latches the post-step challenge onto the PUF mux selects,
// fires the race, waits SETTLE_CYCLES, samples the arbiter response and packs
// responses into RESP_W-bit words delivered over a valid/ready port.
// Ports:
//   clk, rst        : clock, asynchronous active-low reset
//   start, num_crp  : begin a run of num_crp CRPs (accepted only when idle)
//   abort           : end any run, back to idle next cycle, no done pulse
//   lfsr_step       : one-cycle LFSR advance
//   chal_in         : current LFSR challenge
//   puf_launch      : one-cycle race launch
//   chal_out        : challenge held on the PUF mux selects
//   puf_resp        : arbiter output
//   out_valid/ready : packed-word handshake
//   out_data        : packed responses, first response in bit 0
//   out_nbits       : valid bits in out_data
//   out_last        : word is the final one of the run
//   busy            : any state other than idle
//   done            : one-cycle pulse at normal run end
// -----------------------------------------------------------------------------
module puf_crp_controller
    import puf_ctrl_pkg::*;
#(
    parameter int N             = 32,
    parameter int RESP_W        = RESP_W_DEF,
    parameter int SETTLE_CYCLES = 8,
    parameter int CNT_W         = CNT_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       abort,
    input  logic [CNT_W-1:0]           num_crp,
    output logic                       lfsr_step,
    input  logic [N-1:0]               chal_in,
    output logic                       puf_launch,
    output logic [N-1:0]               chal_out,
    input  logic                       puf_resp,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [RESP_W-1:0]          out_data,
    output logic [nbits_w(RESP_W)-1:0] out_nbits,
    output logic                       out_last,
    output logic                       busy,
    output logic                       done
);

    localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] num_crp_q;
    logic [CNT_W-1:0] crp_cnt_q;
    logic [SET_W-1:0] settle_q;

    logic pk_clr;
    logic pk_wr;
    logic pk_full;
    logic crp_last;   // the CRP being captured now is the last of the run
    logic word_last;  // every CRP of the run has been captured

    assign crp_last  = ((crp_cnt_q + CNT_W'(1)) == num_crp_q);
    assign word_last = (crp_cnt_q == num_crp_q);

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next state and state-decoded outputs. Outputs depend on state_q only,
    // so out_ready never reaches out_valid combinationally.
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case statement can leave one unassigned and infer a latch.
        state_d    = state_q;
        lfsr_step  = 1'b0;
        puf_launch = 1'b0;
        out_valid  = 1'b0;
        out_last   = 1'b0;
        busy       = (state_q != S_IDLE);
        done       = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (num_crp == '0) ? S_DONE : S_STEP;
                end
            end
            S_STEP: begin
                lfsr_step = 1'b1;
                state_d   = S_LAUNCH;
            end
            S_LAUNCH: begin
                puf_launch = 1'b1;
                state_d    = S_SETTLE;
            end
            S_SETTLE: begin
                if (settle_q == '0) begin
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                state_d = (pk_full || crp_last) ? S_EMIT : S_STEP;
            end
            S_EMIT: begin
                out_valid = 1'b1;
                out_last  = word_last;
                if (out_ready) begin
                    state_d = word_last ? S_DONE : S_STEP;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort wins over start and over a same-cycle handshake.
        if (abort) begin
            state_d = S_IDLE;
        end
    end

    // ------------------------------------------------------------------------
    // Run counters, settle timer and the held challenge. Nothing here moves
    // in an abort cycle, which is what keeps chal_out unchanged on abort.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            num_crp_q <= '0;
            crp_cnt_q <= '0;
            settle_q  <= '0;
            chal_out  <= '0;
        end else if (!abort) begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        num_crp_q <= num_crp;
                        crp_cnt_q <= '0;
                    end
                end
                S_LAUNCH: begin
                    // chal_in already reflects the step taken in S_STEP.
                    chal_out <= chal_in;
                    settle_q <= SET_W'(SETTLE_CYCLES - 1);
                end
                S_SETTLE: begin
                    if (settle_q != '0) begin
                        settle_q <= settle_q - SET_W'(1);
                    end
                end
                S_CAPTURE: begin
                    crp_cnt_q <= crp_cnt_q + CNT_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Response packer: cleared on an accepted start and on each handshake,
    // written once per CAPTURE.
    // ------------------------------------------------------------------------
    assign pk_clr = !abort && (((state_q == S_IDLE) && start) ||
                               ((state_q == S_EMIT) && out_ready));
    assign pk_wr  = !abort && (state_q == S_CAPTURE);

    puf_resp_packer #(
        .RESP_W (RESP_W)
    ) u_packer (
        .clk     (clk),
        .rst     (rst),
        .clr     (pk_clr),
        .wr_en   (pk_wr),
        .bit_in  (puf_resp),
        .data    (out_data),
        .bit_cnt (out_nbits),
        .full    (pk_full)
    );

endmodule

// File: tb/tb_puf_crp_controller.sv
// -----------------------------------------------------------------------------
// tb_puf_crp_controller
// Drives randomized runs of the PUF CRP controller against a behavioural model
// of the external LFSR and arbiter PUF. Expected words and challenges are
// queued when a run is started; a monitor pops and compares them whenever the
// DUT presents a launch or completes a handshake.
// -----------------------------------------------------------------------------
module tb_puf_crp_controller;

    localparam int N      = 32;
    localparam int RESP_W = 32;
    localparam int SETTLE = 8;
    localparam int CNT_W  = 16;
    localparam int NB_W   = 6;
    localparam int PER    = SETTLE + 3;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic              out_ready = 1'b0;
    logic [CNT_W-1:0]  num_crp = '0;
    logic              puf_resp;
    logic [N-1:0]      chal_in;
    logic [N-1:0]      chal_out;
    logic              lfsr_step;
    logic              puf_launch;
    logic              out_valid;
    logic [RESP_W-1:0] out_data;
    logic [NB_W-1:0]   out_nbits;
    logic              out_last;
    logic              busy;
    logic              done;

    always #5 clk = ~clk;

    puf_crp_controller #(
        .N             (N),
        .RESP_W        (RESP_W),
        .SETTLE_CYCLES (SETTLE),
        .CNT_W         (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .num_crp    (num_crp),
        .lfsr_step  (lfsr_step),
        .chal_in    (chal_in),
        .puf_launch (puf_launch),
        .chal_out   (chal_out),
        .puf_resp   (puf_resp),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_nbits  (out_nbits),
        .out_last   (out_last),
        .busy       (busy),
        .done       (done)
    );

    // ---------------- checking infrastructure ----------------
    typedef struct packed {
        logic [RESP_W-1:0] data;
        logic [NB_W-1:0]   nbits;
        logic              last;
    } word_t;

    word_t        exp_q[$];
    logic [N-1:0] chal_q[$];
    int           checks = 0;
    int           errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- external datapath models ----------------
    function automatic logic [N-1:0] lfsr_next(input logic [N-1:0] s);
        return {s[N-2:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
    endfunction

    logic [N-1:0] lfsr_q = 32'hACE1_1234;
    always @(posedge clk) if (lfsr_step) lfsr_q <= lfsr_next(lfsr_q);
    assign chal_in = lfsr_q;

    // PUF: either a per-run response table indexed by launch number, or the
    // parity of the held challenge under a key (key=1 gives chal[0]).
    bit           tbl_mode = 1'b0;
    logic [N-1:0] key = 32'h1;
    bit           tbl[256];
    int           launch_total = 0;
    int           launch_base = 0;
    always @(posedge clk) if (puf_launch) launch_total <= launch_total + 1;
    always_comb begin
        int idx;
        idx = launch_total - launch_base - 1;
        puf_resp = tbl_mode ? tbl[idx[7:0]] : ^(chal_out & key);
    end

    // Expected results of a run of n CRPs starting from the current LFSR state.
    task automatic build_expect(input int n);
        logic [N-1:0] s;
        word_t        w;
        int           nb;
        bit           b;
        s  = lfsr_q;
        w  = '0;
        nb = 0;
        for (int k = 0; k < n; k++) begin
            s = lfsr_next(s);
            chal_q.push_back(s);
            b = tbl_mode ? tbl[k % 256] : ^(s & key);
            w.data[nb] = b;
            nb++;
            if (nb == RESP_W || k == n - 1) begin
                w.nbits = NB_W'(nb);
                w.last  = (k == n - 1);
                exp_q.push_back(w);
                w  = '0;
                nb = 0;
            end
        end
    endtask

    // ---------------- monitor ----------------
    int    cyc = 0;
    int    step_count = 0;
    int    done_count = 0;
    int    step_times[$];
    bit    launch_d = 1'b0;
    bit    done_due = 1'b0;
    bit    prev_hold = 1'b0;
    word_t prev_word;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done_due) begin
            check("done_after_last_handshake", done, 1'b1);
            done_due = 1'b0;
        end
        if (done) done_count++;
        if (lfsr_step) begin
            step_count++;
            step_times.push_back(cyc);
            check("step_vs_launch", puf_launch, 1'b0);
            check("step_while_valid", out_valid, 1'b0);
        end
        if (launch_d) begin
            if (chal_q.size() == 0) check("chal_unexpected_launch", chal_q.size(), 1);
            else check("chal_out", chal_out, chal_q.pop_front());
        end
        launch_d = puf_launch;
        if (prev_hold) begin
            check("valid_held", out_valid, 1'b1);
            check("word_held", {out_data, out_nbits, out_last}, prev_word);
        end
        if (out_valid && out_ready && !abort) begin
            if (exp_q.size() == 0) begin
                check("word_unexpected", exp_q.size(), 1);
            end else begin
                word_t e;
                e = exp_q.pop_front();
                check("out_data", out_data, e.data);
                check("out_nbits", out_nbits, e.nbits);
                check("out_last", out_last, e.last);
                if (e.last) done_due = 1'b1;
            end
        end
        prev_hold = out_valid && !out_ready && !abort;
        prev_word = {out_data, out_nbits, out_last};
    end

    // ---------------- driver ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_lfsr_step"}, lfsr_step, 1'b0);
        check({tag, "_puf_launch"}, puf_launch, 1'b0);
        check({tag, "_out_valid"}, out_valid, 1'b0);
        check({tag, "_out_last"}, out_last, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_out_data"}, out_data, '0);
        check({tag, "_out_nbits"}, out_nbits, '0);
        check({tag, "_chal_out"}, chal_out, '0);
    endtask

    task automatic begin_run(input int n);
        build_expect(n);
        launch_base = launch_total;
        num_crp = CNT_W'(n);
        start = 1'b1;
        tick();
        start = 1'b0;
        num_crp = CNT_W'($urandom);  // must be ignored after the accepted start
    endtask

    task automatic run(input int n, input int ready_pct, input bit stall_first, input bit poke);
        int  d0;
        int  s0;
        int  budget;
        int  sc;
        bit  stalled;
        logic [RESP_W-1:0] held;
        stalled = 1'b0;
        d0 = done_count;
        s0 = step_count;
        budget = n * PER + 400;
        begin_run(n);
        for (int c = 0; c < budget && done_count == d0; c++) begin
            if (stall_first && !stalled && out_valid) begin
                out_ready = 1'b0;
                held = out_data;
                sc = step_count;
                repeat (20) begin
                    @(negedge clk);
                    check("stall_valid", out_valid, 1'b1);
                    check("stall_data", out_data, held);
                end
                check("stall_no_step", step_count, sc);
                stalled = 1'b1;
            end
            if (poke && c == 15) begin
                num_crp = CNT_W'(n + 5);
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            out_ready = ($urandom_range(99) < ready_pct);
            tick();
        end
        start = 1'b0;
        out_ready = 1'b0;
        check("run_done_pulses", done_count - d0, 1);
        check("run_lfsr_steps", step_count - s0, n);
        check("run_words_left", exp_q.size(), 0);
        check("run_chals_left", chal_q.size(), 0);
        @(negedge clk);
        check("run_idle_after", busy, 1'b0);
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int st0;
        int d0;
        int s0;
        int c;
        for (int i = 0; i < 256; i++) tbl[i] = 1'($urandom);

        // Reset values.
        #2;
        check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        tick();

        // Three CRPs, responses 1,0,1, no backpressure.
        tbl_mode = 1'b1;
        tbl[0] = 1'b1;
        tbl[1] = 1'b0;
        tbl[2] = 1'b1;
        st0 = step_times.size();
        run(3, 100, 1'b0, 1'b0);
        check("step_gap_1", step_times[st0 + 1] - step_times[st0], PER);
        check("step_gap_2", step_times[st0 + 2] - step_times[st0 + 1], PER);

        // 64 CRPs, response = challenge bit 0: two full words.
        tbl_mode = 1'b0;
        key = 32'h1;
        run(64, 100, 1'b0, 1'b0);

        // Backpressure on the first word of a two-word run.
        key = $urandom;
        run(40, 100, 1'b1, 1'b0);

        // Zero-length run.
        d0 = done_count;
        s0 = step_count;
        num_crp = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        @(negedge clk);
        check("zero_done", done, 1'b1);
        check("zero_valid", out_valid, 1'b0);
        @(negedge clk);
        check("zero_done_once", done, 1'b0);
        check("zero_busy", busy, 1'b0);
        check("zero_steps", step_count - s0, 0);
        check("zero_done_count", done_count - d0, 1);
        tick();

        // Start while busy must be ignored.
        key = $urandom;
        run(20, 70, 1'b0, 1'b1);

        // Abort in EMIT together with out_ready.
        key = $urandom;
        begin_run(5);
        out_ready = 1'b0;
        c = 0;
        while (!out_valid && c < 200) begin
            tick();
            c++;
        end
        check("abort_reached_emit", out_valid, 1'b1);
        d0 = done_count;
        abort = 1'b1;
        out_ready = 1'b1;
        tick();
        abort = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        check("abort_valid_dropped", out_valid, 1'b0);
        check("abort_idle", busy, 1'b0);
        check("abort_word_not_taken", exp_q.size(), 1);
        exp_q.delete();
        chal_q.delete();
        repeat (3) @(negedge clk);
        check("abort_no_done", done_count, d0);
        tick();
        run(5, 100, 1'b0, 1'b0);

        // Asynchronous reset in the middle of SETTLE.
        begin_run(10);
        c = 0;
        while (!puf_launch && c < 50) begin
            tick();
            c++;
        end
        check("rst_reached_launch", puf_launch, 1'b1);
        repeat (3) tick();
        rst = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        chal_q.delete();
        s0 = step_count;
        repeat (20) tick();
        check("midrst_no_step", step_count, s0);
        check("midrst_idle", busy, 1'b0);

        // Boundary lengths and randomized runs.
        key = $urandom;
        run(1, 60, 1'b0, 1'b0);
        run(32, 60, 1'b0, 1'b0);
        run(33, 60, 1'b0, 1'b0);
        for (int r = 0; r < 6; r++) begin
            key = $urandom;
            tbl_mode = r[0];
            run($urandom_range(3, 80), $urandom_range(30, 100), 1'b0, r == 2);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
